// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - LSQ-side and memory-side signal bundle of the data-memory port arbiter
interface mem_port_arbiter_if;
    logic        st_commit_valid;
    logic        st_commit_ready;
    logic [31:0] st_commit_addr;
    logic [31:0] st_commit_data;
    logic        st_commit_sh;

    logic        ld_req_valid;
    logic        ld_req_ready;
    logic [31:0] ld_req_addr;
    logic [2:0]  ld_req_func3;
    logic [6:0]  ld_req_pd;
    logic [4:0]  ld_req_rob;

    logic        mem_store_wb;
    logic [31:0] mem_st_addr;
    logic [31:0] mem_st_data;
    logic        mem_st_sh;
    logic        mem_load;
    logic [31:0] mem_ld_addr;
    logic [2:0]  mem_ld_func3;
    logic [6:0]  mem_ld_pd;
    logic [4:0]  mem_ld_rob;

    modport master (
        output st_commit_valid, st_commit_addr, st_commit_data, st_commit_sh,
        output ld_req_valid, ld_req_addr, ld_req_func3, ld_req_pd, ld_req_rob,
        input  st_commit_ready, ld_req_ready,
        input  mem_store_wb, mem_st_addr, mem_st_data, mem_st_sh,
        input  mem_load, mem_ld_addr, mem_ld_func3, mem_ld_pd, mem_ld_rob
    );

    modport slave (
        input  st_commit_valid, st_commit_addr, st_commit_data, st_commit_sh,
        input  ld_req_valid, ld_req_addr, ld_req_func3, ld_req_pd, ld_req_rob,
        output st_commit_ready, ld_req_ready,
        output mem_store_wb, mem_st_addr, mem_st_data, mem_st_sh,
        output mem_load, mem_ld_addr, mem_ld_func3, mem_ld_pd, mem_ld_rob
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - store buffer plus load/store arbiter for the single data-memory port
// Optional perf counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
    parameter int SB_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int LOW_WATER    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    mem_port_arbiter_if.slave   bus,
    output logic                sb_empty,
    output logic [31:0]         perf_ld_stall,
    output logic [31:0]         perf_st_forced
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] S_LOAD_PRI = 1'b0;
    localparam logic [0:0] S_DRAIN    = 1'b1;

    logic [31:0]      sb_addr [SB_DEPTH];
    logic [31:0]      sb_data [SB_DEPTH];
    logic             sb_sh   [SB_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after_pop;
    logic             sb_full;

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic [SC_W-1:0]  starve_cnt;

    logic             hazard;
    logic             overlap;
    logic [32:0]      ld_lo;
    logic [32:0]      ld_hi;
    logic [32:0]      st_lo;
    logic [32:0]      st_hi;
    logic [PTR_W-1:0] rel;

    logic             drain_active;
    logic             ld_ok;
    logic             ld_grant;
    logic             st_grant;
    logic             push;
    logic             pop;

    assign sb_full  = (count == CNT_W'(SB_DEPTH));
    assign sb_empty = (count == '0);

    assign bus.st_commit_ready = !sb_full;
    assign bus.ld_req_ready    = ld_grant;

    // Byte-range overlap against every live SB entry; 33-bit bounds keep the top-of-memory case from wrapping.
    always_comb begin
        ld_lo   = {1'b0, bus.ld_req_addr};
        ld_hi   = ld_lo + ((bus.ld_req_func3 == 3'b100) ? 33'd0 : 33'd3);
        overlap = 1'b0;
        rel     = '0;
        st_lo   = '0;
        st_hi   = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            rel   = PTR_W'(i) - head;
            st_lo = {1'b0, sb_addr[i]};
            st_hi = st_lo + (sb_sh[i] ? 33'd1 : 33'd3);
            if (({1'b0, rel} < count) && (st_lo <= ld_hi) && (ld_lo <= st_hi)) begin
                overlap = 1'b1;
            end
        end
        hazard = bus.ld_req_valid && overlap;
    end

    // DRAIN with nothing left to drain behaves as LOAD_PRI, so a blocked load can go the cycle its store leaves.
    assign drain_active    = (state == S_DRAIN) && !sb_empty;
    assign ld_ok           = bus.ld_req_valid && !flush && !hazard && (starve_cnt < SC_W'(STARVE_LIMIT));
    assign ld_grant        = !drain_active && ld_ok;
    assign st_grant        = !sb_empty && !ld_grant;
    assign push            = bus.st_commit_valid && !sb_full;
    assign pop             = st_grant;
    assign count_after_pop = count - CNT_W'(pop);

    always_comb begin
        state_next = state;
        if (drain_active) begin
            if (((count_after_pop <= CNT_W'(LOW_WATER)) && !hazard) || (count_after_pop == '0)) begin
                state_next = S_LOAD_PRI;
            end else begin
                state_next = S_DRAIN;
            end
        end else if (sb_full || hazard) begin
            state_next = S_DRAIN;
        end else begin
            state_next = S_LOAD_PRI;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD_PRI;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (sb_empty || st_grant) begin
            starve_cnt <= '0;
        end else if (ld_grant && (starve_cnt < SC_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage needs no reset: liveness is tracked purely by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail] <= bus.st_commit_addr;
            sb_data[tail] <= bus.st_commit_data;
            sb_sh[tail]   <= bus.st_commit_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_store_wb <= 1'b0;
            bus.mem_st_addr  <= '0;
            bus.mem_st_data  <= '0;
            bus.mem_st_sh    <= 1'b0;
            bus.mem_load     <= 1'b0;
            bus.mem_ld_addr  <= '0;
            bus.mem_ld_func3 <= '0;
            bus.mem_ld_pd    <= '0;
            bus.mem_ld_rob   <= '0;
        end else begin
            bus.mem_store_wb <= st_grant;
            bus.mem_st_addr  <= st_grant ? sb_addr[head] : '0;
            bus.mem_st_data  <= st_grant ? sb_data[head] : '0;
            bus.mem_st_sh    <= st_grant ? sb_sh[head]   : 1'b0;
            bus.mem_load     <= ld_grant;
            bus.mem_ld_addr  <= ld_grant ? bus.ld_req_addr  : '0;
            bus.mem_ld_func3 <= ld_grant ? bus.ld_req_func3 : '0;
            bus.mem_ld_pd    <= ld_grant ? bus.ld_req_pd    : '0;
            bus.mem_ld_rob   <= ld_grant ? bus.ld_req_rob   : '0;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic st_forced;

    // In LOAD_PRI a store only beats an eligible load when the starve limit has been reached.
    assign st_forced = st_grant && (drain_active || (bus.ld_req_valid && !flush && !hazard));

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ld_stall  <= '0;
            perf_st_forced <= '0;
        end else begin
            if (bus.ld_req_valid && !ld_grant) begin
                perf_ld_stall <= perf_ld_stall + 32'd1;
            end
            if (st_forced) begin
                perf_st_forced <= perf_st_forced + 32'd1;
            end
        end
    end
`else
    assign perf_ld_stall  = '0;
    assign perf_st_forced = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        sb_empty;
    logic [31:0] perf_ld_stall;
    logic [31:0] perf_st_forced;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .bus            (bus),
        .sb_empty       (sb_empty),
        .perf_ld_stall  (perf_ld_stall),
        .perf_st_forced (perf_st_forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        sv;
        logic [31:0] sa;
        logic        sh;
        logic        lv;
        logic [31:0] la;
        logic [2:0]  lf3;
        logic        e_strdy;
        logic        e_ldrdy;
        logic        e_wb;
        logic [31:0] e_sta;
        logic        e_ld;
        logic [31:0] e_lda;
        logic [2:0]  e_f3;
        logic        e_empty;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic fl, logic sv, logic [31:0] sa, logic sh,
                               logic lv, logic [31:0] la, logic [2:0] lf3,
                               logic e_strdy, logic e_ldrdy,
                               logic e_wb, logic [31:0] e_sta,
                               logic e_ld, logic [31:0] e_lda, logic [2:0] e_f3,
                               logic e_empty);
        vec_t r;
        r.flush = fl; r.sv = sv; r.sa = sa; r.sh = sh;
        r.lv = lv; r.la = la; r.lf3 = lf3;
        r.e_strdy = e_strdy; r.e_ldrdy = e_ldrdy;
        r.e_wb = e_wb; r.e_sta = e_sta;
        r.e_ld = e_ld; r.e_lda = e_lda; r.e_f3 = e_f3;
        r.e_empty = e_empty;
        return r;
    endfunction

    function automatic logic [31:0] st_data_of(logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic fl, logic sv, logic [31:0] sa, logic sh,
                         logic lv, logic [31:0] la, logic [2:0] lf3);
        flush               = fl;
        bus.st_commit_valid = sv;
        bus.st_commit_addr  = sa;
        bus.st_commit_data  = st_data_of(sa);
        bus.st_commit_sh    = sh;
        bus.ld_req_valid    = lv;
        bus.ld_req_addr     = la;
        bus.ld_req_func3    = lf3;
        bus.ld_req_pd       = 7'(la >> 2);
        bus.ld_req_rob      = 5'(la);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, LW);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, LW);

        //        fl sv sa            sh lv la          lf3     srdy lrdy wb sta           ld lda     f3      empty
        vecs.push_back(v(0, 0, 0,            0, 1, 32'h100, LW,     1, 1, 0, 0,            0, 0,       0,      1));
        vecs.push_back(v(0, 0, 0,            0, 0, 0,       LW,     1, 0, 0, 0,            1, 32'h100, LW,     1));
        vecs.push_back(v(0, 1, 32'h40,       0, 0, 0,       LW,     1, 0, 0, 0,            0, 0,       0,      1));
        vecs.push_back(v(0, 0, 0,            0, 1, 32'h42,  LW,     1, 0, 0, 0,            0, 0,       0,      0));
        vecs.push_back(v(0, 0, 0,            0, 1, 32'h42,  LW,     1, 1, 1, 32'h40,       0, 0,       0,      1));
        vecs.push_back(v(0, 0, 0,            0, 0, 0,       LW,     1, 0, 0, 0,            1, 32'h42,  LW,     1));
        vecs.push_back(v(0, 1, 32'h40,       1, 0, 0,       LW,     1, 0, 0, 0,            0, 0,       0,      1));
        vecs.push_back(v(0, 0, 0,            0, 1, 32'h42,  LBU,    1, 1, 0, 0,            0, 0,       0,      0));
        vecs.push_back(v(0, 0, 0,            0, 0, 0,       LW,     1, 0, 0, 0,            1, 32'h42,  LBU,    0));
        vecs.push_back(v(0, 0, 0,            0, 0, 0,       LW,     1, 0, 1, 32'h40,       0, 0,       0,      1));
        vecs.push_back(v(0, 1, 32'h300,      0, 1, 32'h200, LW,     1, 1, 0, 0,            0, 0,       0,      1));
        vecs.push_back(v(0, 1, 32'h310,      0, 1, 32'h200, LW,     1, 1, 0, 0,            1, 32'h200, LW,     0));
        vecs.push_back(v(0, 1, 32'h320,      0, 1, 32'h200, LW,     1, 1, 0, 0,            1, 32'h200, LW,     0));
        vecs.push_back(v(0, 1, 32'h330,      0, 1, 32'h200, LW,     1, 1, 0, 0,            1, 32'h200, LW,     0));
        vecs.push_back(v(0, 1, 32'h340,      0, 1, 32'h200, LW,     0, 1, 0, 0,            1, 32'h200, LW,     0));
        vecs.push_back(v(0, 0, 0,            0, 1, 32'h200, LW,     0, 0, 0, 0,            1, 32'h200, LW,     0));
        vecs.push_back(v(0, 0, 0,            0, 1, 32'h200, LW,     1, 0, 1, 32'h300,      0, 0,       0,      0));
        vecs.push_back(v(0, 0, 0,            0, 1, 32'h200, LW,     1, 0, 1, 32'h310,      0, 0,       0,      0));
        vecs.push_back(v(0, 0, 0,            0, 1, 32'h200, LW,     1, 1, 1, 32'h320,      0, 0,       0,      0));
        vecs.push_back(v(0, 0, 0,            0, 0, 0,       LW,     1, 0, 0, 0,            1, 32'h200, LW,     0));
        vecs.push_back(v(0, 0, 0,            0, 0, 0,       LW,     1, 0, 1, 32'h330,      0, 0,       0,      1));
        vecs.push_back(v(1, 0, 0,            0, 1, 32'h100, LW,     1, 0, 0, 0,            0, 0,       0,      1));
        vecs.push_back(v(0, 0, 0,            0, 0, 0,       LW,     1, 0, 0, 0,            0, 0,       0,      1));
        vecs.push_back(v(0, 1, 32'h500,      0, 0, 0,       LW,     1, 0, 0, 0,            0, 0,       0,      1));
        vecs.push_back(v(1, 0, 0,            0, 1, 32'h600, LW,     1, 0, 0, 0,            0, 0,       0,      0));
        vecs.push_back(v(0, 0, 0,            0, 0, 0,       LW,     1, 0, 1, 32'h500,      0, 0,       0,      1));
        vecs.push_back(v(0, 1, 32'h700,      0, 0, 0,       LW,     1, 0, 0, 0,            0, 0,       0,      1));
        vecs.push_back(v(0, 1, 32'h704,      0, 0, 0,       LW,     1, 0, 0, 0,            0, 0,       0,      0));
        vecs.push_back(v(0, 0, 0,            0, 0, 0,       LW,     1, 0, 1, 32'h700,      0, 0,       0,      0));
        vecs.push_back(v(0, 0, 0,            0, 0, 0,       LW,     1, 0, 1, 32'h704,      0, 0,       0,      1));
        vecs.push_back(v(0, 1, 32'h40,       1, 0, 0,       LW,     1, 0, 0, 0,            0, 0,       0,      1));
        vecs.push_back(v(0, 0, 0,            0, 1, 32'h41,  LBU,    1, 0, 0, 0,            0, 0,       0,      0));
        vecs.push_back(v(0, 0, 0,            0, 1, 32'h41,  LBU,    1, 1, 1, 32'h40,       0, 0,       0,      1));
        vecs.push_back(v(0, 0, 0,            0, 0, 0,       LW,     1, 0, 0, 0,            1, 32'h41,  LBU,    1));
        vecs.push_back(v(0, 1, 32'hFFFFFFFE, 0, 0, 0,       LW,     1, 0, 0, 0,            0, 0,       0,      1));
        vecs.push_back(v(0, 0, 0,            0, 1, 32'h0,   LW,     1, 1, 0, 0,            0, 0,       0,      0));
        vecs.push_back(v(0, 0, 0,            0, 0, 0,       LW,     1, 0, 0, 0,            1, 32'h0,   LW,     0));
        vecs.push_back(v(0, 0, 0,            0, 1, 32'h80,  3'b111, 1, 1, 1, 32'hFFFFFFFE, 0, 0,       0,      1));
        vecs.push_back(v(0, 0, 0,            0, 0, 0,       LW,     1, 0, 0, 0,            1, 32'h80,  3'b111, 1));

        do_reset();
        @(negedge clk);
        check("rst_sb_empty", 32'(sb_empty), 32'd1);
        check("rst_st_ready", 32'(bus.st_commit_ready), 32'd1);
        check("rst_store_wb", 32'(bus.mem_store_wb), 32'd0);
        check("rst_load", 32'(bus.mem_load), 32'd0);
        check("rst_st_addr", bus.mem_st_addr, 32'd0);
        check("rst_ld_addr", bus.mem_ld_addr, 32'd0);
        check("rst_perf_stall", perf_ld_stall, 32'd0);
        check("rst_perf_forced", perf_st_forced, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step();
            drive(vecs[i].flush, vecs[i].sv, vecs[i].sa, vecs[i].sh,
                  vecs[i].lv, vecs[i].la, vecs[i].lf3);
            @(negedge clk);
            check($sformatf("v%0d_st_ready", i), 32'(bus.st_commit_ready), 32'(vecs[i].e_strdy));
            check($sformatf("v%0d_ld_ready", i), 32'(bus.ld_req_ready), 32'(vecs[i].e_ldrdy));
            check($sformatf("v%0d_store_wb", i), 32'(bus.mem_store_wb), 32'(vecs[i].e_wb));
            check($sformatf("v%0d_load", i), 32'(bus.mem_load), 32'(vecs[i].e_ld));
            check($sformatf("v%0d_sb_empty", i), 32'(sb_empty), 32'(vecs[i].e_empty));
            if (vecs[i].e_wb) begin
                check($sformatf("v%0d_st_addr", i), bus.mem_st_addr, vecs[i].e_sta);
                check($sformatf("v%0d_st_data", i), bus.mem_st_data, st_data_of(vecs[i].e_sta));
            end
            if (vecs[i].e_ld) begin
                check($sformatf("v%0d_ld_addr", i), bus.mem_ld_addr, vecs[i].e_lda);
                check($sformatf("v%0d_ld_func3", i), 32'(bus.mem_ld_func3), 32'(vecs[i].e_f3));
                check($sformatf("v%0d_ld_pd", i), 32'(bus.mem_ld_pd), 32'(7'(vecs[i].e_lda >> 2)));
                check($sformatf("v%0d_ld_rob", i), 32'(bus.mem_ld_rob), 32'(5'(vecs[i].e_lda)));
            end
        end

        // Starvation: one buffered store under a steady stream of non-overlapping loads.
        do_reset();
        drive(0, 1, 32'h900, 0, 1, 32'h100, LW);
        @(negedge clk);
        check("starve_first_ld", 32'(bus.ld_req_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            step();
            drive(0, 0, 0, 0, 1, 32'h100, LW);
            @(negedge clk);
            check($sformatf("starve_ld%0d", k), 32'(bus.ld_req_ready), 32'd1);
        end
        step();
        @(negedge clk);
        check("starve_forced_no_ld", 32'(bus.ld_req_ready), 32'd0);
        step();
        @(negedge clk);
        check("starve_store_wb", 32'(bus.mem_store_wb), 32'd1);
        check("starve_store_addr", bus.mem_st_addr, 32'h900);
        check("starve_cnt_zero", 32'(dut.starve_cnt), 32'd0);
        check("starve_ld_resumes", 32'(bus.ld_req_ready), 32'd1);

        // Reset arriving while DRAIN is popping a full SB.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 32'hA00 + 32'(16 * k), 0, 1, 32'h100, LW);
            step();
        end
        drive(0, 0, 0, 0, 1, 32'h100, LW);
        @(negedge clk);
        check("mid_full_st_ready", 32'(bus.st_commit_ready), 32'd0);
        step();
        @(negedge clk);
        check("mid_drain_no_ld", 32'(bus.ld_req_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, LW);
        @(negedge clk);
        check("mid_rst_sb_empty", 32'(sb_empty), 32'd1);
        check("mid_rst_store_wb", 32'(bus.mem_store_wb), 32'd0);
        check("mid_rst_load", 32'(bus.mem_load), 32'd0);
        check("mid_rst_st_addr", bus.mem_st_addr, 32'd0);
        check("mid_rst_st_ready", 32'(bus.st_commit_ready), 32'd1);
        step();
        @(negedge clk);
        check("mid_rst_no_stale_wb", 32'(bus.mem_store_wb), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
